mem_port_arbiter: RTL

Shares one single-port synchronous data memory between NREQ requesters, e.g. several multiplier-sequencing controllers plus a host loader. Grants one access at a time using round-robin order and forwards the winner's command to the memory port. Returns read data to the winner with a one-cycle valid pulse. Sits between the per-datapath controllers and the memory macro.

---
 rtl/mem_port_arbiter_if.sv | 30 +++
 rtl/mem_port_arbiter.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundle between mem_port_arbiter, its requesters and the single-port memory macro.
// slave is the arbiter's view; master is the requester/memory side.
interface mem_port_arbiter_if #(
  parameter int unsigned NREQ = 3,
  parameter int unsigned AW   = 4,
  parameter int unsigned DW   = 16
);
  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    we;
  logic [NREQ*AW-1:0] addr;
  logic [NREQ*DW-1:0] wdata;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    rvalid;
  logic [DW-1:0]      rdata;
  logic               mem_en;
  logic               mem_we;
  logic [AW-1:0]      mem_addr;
  logic [DW-1:0]      mem_wdata;
  logic [DW-1:0]      mem_rdata;

  modport slave (
    input  req, we, addr, wdata, mem_rdata,
    output gnt, rvalid, rdata, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req, we, addr, wdata, mem_rdata,
    input  gnt, rvalid, rdata, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous memory between NREQ requesters.
// Define FIXED_PRIO0_EN to give requester 0 absolute priority over a round-robin of the rest.
module mem_port_arbiter #(
  parameter int unsigned NREQ   = 3,
  parameter int unsigned AW     = 4,
  parameter int unsigned DW     = 16,
  parameter int unsigned RD_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  mem_port_arbiter_if.slave     bus,
  output logic                  busy
);
  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CW = $clog2(RD_LAT + 1);

  typedef enum logic [1:0] {StIdle, StAccess, StRdWait} state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   last_q, last_d;
  logic [IW-1:0]   win_q, win_d;
  logic            we_q, we_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic [NREQ-1:0] rvalid_q, rvalid_d;
  logic [NREQ-1:0] gnt;
  logic            mem_en, mem_we;

  logic            found;
  logic [IW-1:0]   sel;

  // Winner search starts just after the last served requester.
  always_comb begin
    int idx;
    logic [IW-1:0] cand;
    idx   = 0;
    cand  = '0;
    found = 1'b0;
    sel   = '0;
`ifdef FIXED_PRIO0_EN
    if (bus.req[0]) begin
      found = 1'b1;
    end else begin
      for (int k = 1; k < int'(NREQ); k++) begin
        idx  = ((int'(last_q) - 1 + k) % (int'(NREQ) - 1)) + 1;
        cand = IW'(idx);
        if (!found && bus.req[cand]) begin
          found = 1'b1;
          sel   = cand;
        end
      end
    end
`else
    for (int k = 1; k <= int'(NREQ); k++) begin
      idx  = (int'(last_q) + k) % int'(NREQ);
      cand = IW'(idx);
      if (!found && bus.req[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
`endif
  end

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    win_d    = win_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    rvalid_d = '0;
    gnt      = '0;
    mem_en   = 1'b0;
    mem_we   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          win_d   = sel;
          we_d    = bus.we[sel];
          addr_d  = bus.addr[sel*AW +: AW];
          wdata_d = bus.wdata[sel*DW +: DW];
          state_d = StAccess;
        end
      end
      StAccess: begin
        mem_en     = 1'b1;
        mem_we     = we_q;
        gnt[win_q] = 1'b1;
`ifdef FIXED_PRIO0_EN
        // Requester 0 never moves the pointer shared by the others.
        if (win_q != '0) last_d = win_q;
`else
        last_d = win_q;
`endif
        if (we_q) begin
          state_d = StIdle;
        end else begin
          cnt_d   = CW'(RD_LAT);
          state_d = StRdWait;
        end
      end
      StRdWait: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          rdata_d         = bus.mem_rdata;
          rvalid_d[win_q] = 1'b1;
          state_d         = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      last_q   <= IW'(NREQ - 1);
      win_q    <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      cnt_q    <= '0;
      rdata_q  <= '0;
      rvalid_q <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      win_q    <= win_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  // Captured command registers double as the held memory address/data.
  assign bus.gnt       = gnt;
  assign bus.rvalid    = rvalid_q;
  assign bus.rdata     = rdata_q;
  assign bus.mem_en    = mem_en;
  assign bus.mem_we    = mem_we;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign busy          = (state_q != StIdle);
endmodule
